// File: rtl/pim_array_ctrl.sv
// MMIO front-end for NUM_MACRO CAM/CIM macros: assembles bus words into weight rows and
// activation vectors, fires them as one-cycle strobes, then captures and streams back a result.
module pim_array_ctrl #(
  parameter int  NUM_MACRO = 4,
  parameter int  ROW_W     = 256,
  parameter int  ACT_W     = 288,
  parameter int  RES_W     = 8192,
  parameter int  WL_DEPTH  = 288,
  parameter int  RES_LAT   = 4,
  localparam int SEL_W     = (NUM_MACRO > 1) ? $clog2(NUM_MACRO) : 1,
  localparam int WL_AW     = $clog2(WL_DEPTH + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic                       i_rd_en,
  input  logic [31:0]                i_address,
  input  logic [31:0]                i_data,
  output logic [31:0]                o_data,
  output logic [NUM_MACRO-1:0]       o_weight_out_en,
  output logic [NUM_MACRO*WL_AW-1:0] o_WL_address,
  output logic [NUM_MACRO*ROW_W-1:0] o_cam_data,
  output logic [NUM_MACRO*ROW_W-1:0] o_cim_data,
  output logic [NUM_MACRO-1:0]       o_activation_out_en,
  output logic [NUM_MACRO*ACT_W-1:0] o_activation_out_data,
  input  logic [NUM_MACRO*RES_W-1:0] i_result_in
);

  // state    | meaning
  // S_IDLE   | waiting for a WDATA or ADATA write
  // S_W_FILL | collecting CAM row words, then CIM row words
  // S_W_FIRE | weight strobe cycle
  // S_A_FILL | collecting activation words
  // S_A_FIRE | activation strobe cycle
  // S_WAIT   | counting down the macro result latency
  // S_CAPT   | latching the selected macro's result vector
  typedef enum logic [2:0] {
    S_IDLE, S_W_FILL, S_W_FIRE, S_A_FILL, S_A_FIRE, S_WAIT, S_CAPT
  } state_t;

  localparam int W_WORDS  = 2 * ROW_W / 32;
  localparam int A_WORDS  = ACT_W / 32;
  localparam int R_WORDS  = RES_W / 32;
  localparam int FILL_MAX = (W_WORDS > A_WORDS) ? W_WORDS : A_WORDS;
  localparam int FC_W     = $clog2(FILL_MAX);
  localparam int RP_W     = (R_WORDS > 1) ? $clog2(R_WORDS) : 1;
  localparam int WC_W     = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  localparam logic [FC_W-1:0]  W_LAST    = FC_W'(W_WORDS - 1);
  localparam logic [FC_W-1:0]  A_LAST    = FC_W'(A_WORDS - 1);
  localparam logic [RP_W-1:0]  R_LAST    = RP_W'(R_WORDS - 1);
  localparam logic [WC_W-1:0]  WAIT_LOAD = WC_W'((RES_LAT > 1) ? RES_LAT - 2 : 0);
  localparam logic [WL_AW-1:0] WL_PARK   = WL_AW'(WL_DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_WLADDR = 3'd1;
  localparam logic [2:0] A_WDATA  = 3'd2;
  localparam logic [2:0] A_ADATA  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_RESULT = 3'd5;
  localparam logic [2:0] A_RPTR   = 3'd6;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic               bcast;
  logic               err;
  logic               valid;
  logic [31:0]        wladdr;
  logic [FC_W-1:0]    fill_cnt;
  logic [WC_W-1:0]    wait_cnt;
  logic [RP_W-1:0]    rptr;
  logic [2*ROW_W-1:0] w_buf;
  logic [2*ROW_W-1:0] w_next;
  logic [ACT_W-1:0]   a_buf;
  logic [ACT_W-1:0]   a_next;
  logic [RES_W-1:0]   res_buf;
  logic [NUM_MACRO-1:0] target;

  logic [2:0] reg_sel;
  logic       busy;
  logic       wr_mapped;
  logic       wdata_ok;
  logic       adata_ok;
  logic       wr_err;
  logic       wl_ok;
  logic       sel_ok;
  logic       unused_addr_bits;

  assign reg_sel   = i_address[4:2];
  assign busy      = (state != S_IDLE);
  assign wr_mapped = (reg_sel == A_CTRL) || (reg_sel == A_WLADDR) || (reg_sel == A_WDATA) ||
                     (reg_sel == A_ADATA) || (reg_sel == A_RPTR);
  assign wdata_ok  = i_wr_en && (reg_sel == A_WDATA) && (state == S_IDLE || state == S_W_FILL);
  assign adata_ok  = i_wr_en && (reg_sel == A_ADATA) && (state == S_IDLE || state == S_A_FILL);
  assign wr_err    = i_wr_en && busy && wr_mapped && !wdata_ok && !adata_ok;
  assign wl_ok     = (wladdr < 32'(WL_DEPTH));
  assign sel_ok    = (int'(sel) < NUM_MACRO);
  assign unused_addr_bits = ^{i_address[31:5], i_address[1:0]};

  // Buffers with the incoming word merged in, so the last word can fire without an extra cycle.
  always_comb begin
    w_next = w_buf;
    w_next[int'(fill_cnt)*32 +: 32] = i_data;
    a_next = a_buf;
    a_next[int'(fill_cnt)*32 +: 32] = i_data;
  end

  always_comb begin
    target = '0;
    for (int m = 0; m < NUM_MACRO; m++) target[m] = bcast || (sel == SEL_W'(m));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= S_IDLE;
      sel                   <= '0;
      bcast                 <= 1'b0;
      err                   <= 1'b0;
      valid                 <= 1'b0;
      wladdr                <= '0;
      fill_cnt              <= '0;
      wait_cnt              <= '0;
      rptr                  <= '0;
      w_buf                 <= '0;
      a_buf                 <= '0;
      res_buf               <= '0;
      o_data                <= '0;
      o_weight_out_en       <= '0;
      o_activation_out_en   <= '0;
      o_cam_data            <= '0;
      o_cim_data            <= '0;
      o_activation_out_data <= '0;
      o_WL_address          <= {NUM_MACRO{WL_PARK}};
    end else begin
      o_weight_out_en     <= '0;
      o_activation_out_en <= '0;
      o_WL_address        <= {NUM_MACRO{WL_PARK}};

      if (wr_err) err <= 1'b1;

      if (i_rd_en) begin
        case (reg_sel)
          A_STATUS: o_data <= {29'd0, err, valid, busy};
          A_RESULT: begin
            if (valid) begin
              o_data <= res_buf[int'(rptr)*32 +: 32];
              rptr   <= (rptr == R_LAST) ? '0 : rptr + RP_W'(1);
            end else begin
              o_data <= '0;
            end
          end
          default:  o_data <= '0;
        endcase
      end

      if (i_wr_en && !busy) begin
        case (reg_sel)
          A_CTRL: begin
            sel   <= i_data[SEL_W-1:0];
            bcast <= i_data[8];
            if (i_data[31]) err <= 1'b0;
          end
          A_WLADDR: wladdr <= i_data;
          A_RPTR:   rptr   <= '0;
          default:  ;
        endcase
      end

      case (state)
        S_IDLE, S_W_FILL, S_A_FILL: begin
          if (wdata_ok) begin
            w_buf <= w_next;
            if (fill_cnt == W_LAST) begin
              fill_cnt <= '0;
              state    <= S_W_FIRE;
              if (wl_ok) begin
                for (int m = 0; m < NUM_MACRO; m++) begin
                  if (target[m]) begin
                    o_weight_out_en[m]               <= 1'b1;
                    o_WL_address[m*WL_AW +: WL_AW]   <= wladdr[WL_AW-1:0];
                    o_cam_data[m*ROW_W +: ROW_W]     <= w_next[ROW_W-1:0];
                    o_cim_data[m*ROW_W +: ROW_W]     <= w_next[2*ROW_W-1:ROW_W];
                  end
                end
              end else begin
                err <= 1'b1;
              end
            end else begin
              fill_cnt <= fill_cnt + FC_W'(1);
              state    <= S_W_FILL;
            end
          end else if (adata_ok) begin
            a_buf <= a_next;
            if (fill_cnt == A_LAST) begin
              fill_cnt <= '0;
              valid    <= 1'b0;
              state    <= S_A_FIRE;
              for (int m = 0; m < NUM_MACRO; m++) begin
                if (target[m]) begin
                  o_activation_out_en[m]                <= 1'b1;
                  o_activation_out_data[m*ACT_W +: ACT_W] <= a_next;
                end
              end
            end else begin
              fill_cnt <= fill_cnt + FC_W'(1);
              state    <= S_A_FILL;
            end
          end
        end
        S_W_FIRE: state <= S_IDLE;
        S_A_FIRE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= (RES_LAT > 1) ? S_WAIT : S_CAPT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CAPT;
          else                wait_cnt <= wait_cnt - WC_W'(1);
        end
        S_CAPT: begin
          res_buf <= sel_ok ? i_result_in[int'(sel)*RES_W +: RES_W] : '0;
          valid   <= 1'b1;
          rptr    <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_array_ctrl.sv
// Bench for pim_array_ctrl: register-access vector table, directed corner sequences and
// randomized weight/compute traffic checked against a word-level reference model.
module tb_pim_array_ctrl;

  localparam int NM   = 4;
  localparam int ROW  = 256;
  localparam int ACT  = 288;
  localparam int RES  = 8192;
  localparam int WLD  = 288;
  localparam int LAT  = 4;
  localparam int WLAW = 9;
  localparam int RWRD = RES / 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [NM-1:0]     w_en;
  logic [NM*WLAW-1:0] wl;
  logic [NM*ROW-1:0] cam;
  logic [NM*ROW-1:0] cim;
  logic [NM-1:0]     a_en;
  logic [NM*ACT-1:0] act;
  logic [NM*RES-1:0] res_in;

  pim_array_ctrl dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_wr_en               (wr_en),
    .i_rd_en               (rd_en),
    .i_address             (address),
    .i_data                (wdata),
    .o_data                (rdata),
    .o_weight_out_en       (w_en),
    .o_WL_address          (wl),
    .o_cam_data            (cam),
    .o_cim_data            (cim),
    .o_activation_out_en   (a_en),
    .o_activation_out_data (act),
    .i_result_in           (res_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Strobe monitor, sampled on the falling edge.
  int               w_cnt = 0;
  int               a_cnt = 0;
  int               park_bad = 0;
  logic [NM-1:0]    w_mask;
  logic [NM-1:0]    a_mask;
  logic [NM*WLAW-1:0] w_wl;

  always @(negedge clk) begin
    if (w_en != '0) begin
      w_cnt++;
      w_mask = w_en;
      w_wl   = wl;
    end else if (wl != {NM{9'd288}}) begin
      park_bad++;
    end
    if (a_en != '0) begin
      a_cnt++;
      a_mask = a_en;
    end
  end

  // Reference model state.
  logic [ROW-1:0] m_cam [NM];
  logic [ROW-1:0] m_cim [NM];
  logic [ACT-1:0] m_act [NM];
  logic [31:0]    m_res [RWRD];
  int             m_sel;
  bit             m_bcast;
  bit             m_err;
  bit             m_valid;
  int             m_rptr;

  typedef struct {
    bit          is_wr;
    logic [2:0]  r;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[10];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      m_cam[m] = '0;
      m_cim[m] = '0;
      m_act[m] = '0;
    end
    for (int k = 0; k < RWRD; k++) m_res[k] = '0;
    m_sel = 0; m_bcast = 0; m_err = 0; m_valid = 0; m_rptr = 0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    address = {27'd0, r, 2'b00};
    wdata   = d;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    address = {27'd0, r, 2'b00};
    rd_en   = 1'b1;
    @(posedge clk); #1;
    rd_en   = 1'b0;
    d       = rdata;
  endtask

  task automatic chk_status(input string name);
    logic [31:0] d;
    rd(3'd4, d);
    check(name, d, {29'd0, m_err, m_valid, 1'b0});
  endtask

  task automatic set_ctrl(input int s, input bit b, input bit clr);
    wr(3'd0, {clr, 22'd0, b, 8'(s)});
    m_sel = s;
    m_bcast = b;
    if (clr) m_err = 0;
  endtask

  task automatic read_res();
    logic [31:0] d;
    logic [31:0] e;
    e = m_valid ? m_res[m_rptr] : 32'd0;
    rd(3'd5, d);
    check("result word", d, e);
    if (m_valid) m_rptr = (m_rptr + 1) % RWRD;
  endtask

  function automatic logic [NM-1:0] exp_targets();
    return m_bcast ? {NM{1'b1}} : (NM'(1) << m_sel);
  endfunction

  // Weight load; bad_at >= 0 injects a CTRL write right after that word.
  task automatic op_weight(input int wla, input bit idx_pat, input int bad_at);
    logic [31:0]   w [16];
    logic [NM-1:0] em;
    logic [31:0]   d;
    int            c0;
    for (int i = 0; i < 16; i++) w[i] = idx_pat ? 32'(i) : $urandom;
    em = exp_targets();
    c0 = w_cnt;
    wr(3'd1, wla);
    for (int i = 0; i < 16; i++) begin
      wr(3'd2, w[i]);
      if (i == bad_at) begin
        wr(3'd0, 32'h0000_0103);
        m_err = 1;
        rd(3'd4, d);
        check("err while filling", d, {29'd0, 1'b1, m_valid, 1'b1});
      end
    end
    @(posedge clk); #1;
    if (wla >= WLD) begin
      check("bad wl no strobe", w_cnt - c0, 0);
      m_err = 1;
    end else begin
      check("weight strobes", w_cnt - c0, 1);
      check("weight mask", w_mask, em);
      for (int m = 0; m < NM; m++) begin
        check($sformatf("wl addr m%0d", m), w_wl[m*WLAW +: WLAW], em[m] ? wla : WLD);
        if (em[m]) begin
          for (int i = 0; i < 8; i++) begin
            m_cam[m][32*i +: 32] = w[i];
            m_cim[m][32*i +: 32] = w[8+i];
          end
        end
      end
    end
    for (int m = 0; m < NM; m++) begin
      check($sformatf("cam m%0d", m), cam[m*ROW +: ROW], m_cam[m]);
      check($sformatf("cim m%0d", m), cim[m*ROW +: ROW], m_cim[m]);
    end
    chk_status("status after weight");
  endtask

  task automatic wait_idle(output int n);
    logic [31:0] d;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      rd(3'd4, d);
      if (d[0]) n++;
      else break;
    end
  endtask

  task automatic op_compute(input bit idx_pat, input int nreads);
    logic [31:0]   a [9];
    logic [NM-1:0] em;
    int            c0;
    int            n;
    for (int i = 0; i < 9; i++) a[i] = $urandom;
    for (int w = 0; w < NM*RES/32; w++) res_in[32*w +: 32] = $urandom;
    if (idx_pat) for (int k = 0; k < RWRD; k++) res_in[m_sel*RES + 32*k +: 32] = 32'(k);
    em = exp_targets();
    c0 = a_cnt;
    for (int i = 0; i < 9; i++) wr(3'd3, a[i]);
    wait_idle(n);
    check("busy cycles", n, LAT + 1);
    check("act strobes", a_cnt - c0, 1);
    check("act mask", a_mask, em);
    for (int m = 0; m < NM; m++) begin
      if (em[m]) for (int i = 0; i < 9; i++) m_act[m][32*i +: 32] = a[i];
      check($sformatf("act data m%0d", m), act[m*ACT +: ACT], m_act[m]);
    end
    for (int k = 0; k < RWRD; k++) m_res[k] = res_in[m_sel*RES + 32*k +: 32];
    m_valid = 1;
    m_rptr = 0;
    chk_status("status after compute");
    for (int r = 0; r < nreads; r++) read_res();
  endtask

  initial begin
    logic [31:0] d;
    int          c0;

    tv[0] = '{0, 3'd4, 32'h0,      32'h0};
    tv[1] = '{0, 3'd5, 32'h0,      32'h0};
    tv[2] = '{0, 3'd7, 32'h0,      32'h0};
    tv[3] = '{0, 3'd0, 32'h0,      32'h0};
    tv[4] = '{1, 3'd0, 32'h102,    32'h0};
    tv[5] = '{0, 3'd4, 32'h0,      32'h0};
    tv[6] = '{1, 3'd7, 32'hFFFF,   32'h0};
    tv[7] = '{0, 3'd4, 32'h0,      32'h0};
    tv[8] = '{1, 3'd6, 32'h0,      32'h0};
    tv[9] = '{0, 3'd5, 32'h0,      32'h0};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0; res_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset o_data", rdata, 32'h0);
    check("reset w_en", w_en, 4'h0);
    check("reset a_en", a_en, 4'h0);
    check("reset wl parked", wl, {NM{9'd288}});
    check("reset cam", cam == '0, 1'b1);
    check("reset act", act == '0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      if (tv[i].is_wr) wr(tv[i].r, tv[i].d);
      else begin
        rd(tv[i].r, d);
        check($sformatf("vec%0d", i), d, tv[i].exp);
      end
    end

    // Single-macro weight load with an index pattern.
    set_ctrl(2, 0, 0);
    op_weight(5, 1, -1);
    check("cam2 pattern", cam[2*ROW +: ROW],
          {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});

    // Broadcast activation; capture still uses sel.
    set_ctrl(2, 1, 0);
    op_compute(0, 4);

    // Readout wrap.
    set_ctrl(1, 0, 0);
    op_compute(1, 0);
    for (int r = 0; r < 257; r++) begin
      rd(3'd5, d);
      check($sformatf("wrap read %0d", r), d, r % 256);
    end
    m_rptr = 257 % RWRD;
    read_res();

    // Protocol error mid-fill, then clear.
    set_ctrl(0, 0, 0);
    op_weight(10, 0, 3);
    set_ctrl(0, 0, 1);
    chk_status("err cleared");

    // Out-of-range word line.
    set_ctrl(3, 1, 0);
    op_weight(300, 0, -1);
    set_ctrl(3, 0, 1);
    chk_status("err cleared after bad wl");

    for (int it = 0; it < 16; it++) begin
      set_ctrl($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0)
        op_weight(($urandom_range(0, 7) == 0) ? $urandom_range(288, 320) : $urandom_range(0, 287), 0, -1);
      else
        op_compute(0, $urandom_range(1, 8));
      read_res();
    end

    // Reset while waiting for the result.
    set_ctrl(1, 0, 1);
    c0 = a_cnt;
    for (int i = 0; i < 9; i++) wr(3'd3, $urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("strobe before reset", a_cnt - c0, 1);
    check("post-reset o_data", rdata, 32'h0);
    check("post-reset a_en", a_en, 4'h0);
    check("post-reset wl", wl, {NM{9'd288}});
    check("post-reset act", act == '0, 1'b1);
    chk_status("post-reset status");
    read_res();

    check("wl parked outside strobes", park_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
